// File: rtl/fp_mul_result_collector.sv
// fp_mul_result_collector
// -----------------------------------------------------------------------------
// Receiving end of the floating-point multiplier's AXI-Stream result channel.
// This block collects consecutive 32-bit products into a bank of NUM_RESULTS
// slots and then presents the whole bank downstream.
//
// Ports:
//   sys_clk               - system clock, rising edge
//   sys_rst               - asynchronous, active-high reset
//   s_axis_result_tvalid  - product beat valid
//   s_axis_result_tready  - collector can accept a beat (high only in S_FILL)
//   s_axis_result_tdata   - IEEE-754 single-precision product
//   s_axis_result_tuser   - exception flags: [0] underflow, [1] overflow,
//                           [2] invalid operation
//   finish                - one-cycle pulse that flushes a partially filled bank
//   out_valid             - bank presented downstream
//   out_ready             - downstream accepts the bank
//   out_data              - bank; slot k sits at bits [32k+31:32k], and slot 0
//                           holds the first beat
//   out_count             - number of valid slots in the bank (1..NUM_RESULTS)
//   out_flags             - sticky OR of tuser over the bank's beats
//   dbg_state_o           - current FSM state, exposed for debug and checkers
//
// Handshakes (both channels use the same rule): a transfer happens at a rising
// edge where valid and ready are both high. The producer keeps valid and its
// payload stable until that edge. Ready may depend on the receiver's state,
// but it never depends combinationally on valid.
// -----------------------------------------------------------------------------
module fp_mul_result_collector #(
  parameter int NUM_RESULTS = 16,
  parameter int CNT_W       = 5
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      s_axis_result_tvalid,
  output logic                      s_axis_result_tready,
  input  logic [31:0]               s_axis_result_tdata,
  input  logic [2:0]                s_axis_result_tuser,
  input  logic                      finish,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*NUM_RESULTS-1:0] out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic [2:0]                out_flags,
  output logic [1:0]                dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_RESULTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       flags_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic [31:0]      slot_q [NUM_RESULTS];

  logic beat;

  // Ready is a pure function of the state. A held bank therefore stalls the
  // multiplier, and a slot is never overwritten before the bank is accepted.
  assign s_axis_result_tready = (state_q == S_FILL);
  assign beat                 = s_axis_result_tvalid && s_axis_result_tready;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      flags_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NUM_RESULTS; k++) slot_q[k] <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_q <= S_FILL;
        end

        S_FILL: begin
          if (beat) begin
            slot_q[idx_q] <= s_axis_result_tdata;
            flags_q       <= flags_q | s_axis_result_tuser;
            if (idx_q == LAST_IDX) begin
              // The bank is full. Leaving S_FILL here means idx never wraps,
              // and it is cleared on release.
              state_q <= S_HOLD;
              count_q <= CNT_W'(NUM_RESULTS);
            end else begin
              idx_q <= idx_q + 1'b1;
              if (finish) begin
                // A flush that coincides with a beat keeps that beat.
                state_q <= S_HOLD;
                count_q <= CNT_W'(idx_q) + 1'b1;
              end
            end
          end else if (finish && (idx_q != '0)) begin
            // A flush with no beats pending is dropped, so no empty bank is
            // ever presented.
            state_q <= S_HOLD;
            count_q <= CNT_W'(idx_q);
          end
        end

        S_HOLD: begin
          if (valid_q && out_ready) begin
            state_q <= S_FILL;
            valid_q <= 1'b0;
            idx_q   <= '0;
            flags_q <= '0;
            count_q <= '0;
            for (int k = 0; k < NUM_RESULTS; k++) slot_q[k] <= '0;
          end else begin
            // valid is registered from the state, so it rises one edge after
            // the bank closes.
            valid_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_RESULTS; g++) begin : g_pack
    assign out_data[32*g +: 32] = slot_q[g];
  end

  assign out_valid   = valid_q;
  assign out_count   = count_q;
  assign out_flags   = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_mul_result_collector.sv
// Testbench for fp_mul_result_collector. It applies directed vectors and
// compares the results with hand-computed expected values.
module tb_fp_mul_result_collector;

  localparam int NUM   = 16;
  localparam int CNT_W = 5;

  logic                sys_clk;
  logic                sys_rst;
  logic                tvalid;
  logic                tready;
  logic [31:0]         tdata;
  logic [2:0]          tuser;
  logic                finish;
  logic                out_valid;
  logic                out_ready;
  logic [32*NUM-1:0]   out_data;
  logic [CNT_W-1:0]    out_count;
  logic [2:0]          out_flags;
  logic [1:0]          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: the bench pushes each accepted beat, in order.
  logic [31:0] exp_q[$];

  fp_mul_result_collector #(.NUM_RESULTS(NUM), .CNT_W(CNT_W)) dut (
    .sys_clk              (sys_clk),
    .sys_rst              (sys_rst),
    .s_axis_result_tvalid (tvalid),
    .s_axis_result_tready (tready),
    .s_axis_result_tdata  (tdata),
    .s_axis_result_tuser  (tuser),
    .finish               (finish),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_count            (out_count),
    .out_flags            (out_flags),
    .dbg_state_o          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance one edge. Inputs are driven and outputs sampled #1 after the edge.
  task automatic cycle();
    logic took;
    took = tvalid && tready;
    @(posedge sys_clk);
    if (took) exp_q.push_back(tdata);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] u, input logic fin);
    tvalid = 1'b1;
    tdata  = d;
    tuser  = u;
    finish = fin;
    cycle();
    tvalid = 1'b0;
    tdata  = 32'hDEAD_BEEF;
    tuser  = 3'b111;
    finish = 1'b0;
  endtask

  task automatic flush();
    finish = 1'b1;
    cycle();
    finish = 1'b0;
  endtask

  task automatic wait_bank(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_bank(input string tag, input int cnt, input logic [2:0] flg);
    logic [31:0] e;
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_flags"}, 32'(out_flags), 32'(flg));
    check({tag, "_tready_held"}, 32'(tready), 32'd0);
    check({tag, "_queue_size"}, 32'(exp_q.size()), 32'(cnt));
    for (int k = 0; k < NUM; k++) begin
      if (k < cnt && exp_q.size() > 0) e = exp_q.pop_front();
      else e = 32'h0;
      check($sformatf("%s_slot%0d", tag, k), out_data[32*k +: 32], e);
    end
    exp_q.delete();
  endtask

  task automatic release_bank(input string tag);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_count"}, 32'(out_count), 32'd0);
    check({tag, "_rel_flags"}, 32'(out_flags), 32'd0);
    check({tag, "_rel_slot0"}, out_data[31:0], 32'h0);
    check({tag, "_rel_tready"}, 32'(tready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst   = 1'b1;
    tvalid    = 1'b0;
    tdata     = 32'h0;
    tuser     = 3'b0;
    finish    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_tready", 32'(tready),    32'd0);
    check("rst_count",  32'(out_count), 32'd0);
    check("rst_flags",  32'(out_flags), 32'd0);
    check("rst_data0",  out_data[31:0], 32'h0);
    sys_rst = 1'b0;
    #1;
    check("init_tready", 32'(tready), 32'd0);
    check("init_state",  32'(dbg_state), 32'd0);
    cycle();
    check("fill_tready", 32'(tready), 32'd1);
    check("fill_state",  32'(dbg_state), 32'd1);

    // Full bank: 16 back-to-back beats.
    tvalid = 1'b1;
    tuser  = 3'b000;
    for (int k = 0; k < NUM; k++) begin
      tdata = 32'h3F80_0000 + 32'(k);
      cycle();
    end
    // Keep tvalid high with the 17th beat, which is stalled while the bank is held.
    tdata = 32'h4000_0000;
    check("full_valid_lat0", 32'(out_valid), 32'd0);
    check("full_tready0",    32'(tready),    32'd0);
    cycle();
    check("full_valid_lat1", 32'(out_valid), 32'd1);
    check_bank("full", 16, 3'b000);

    // Backpressure: 10 cycles without out_ready.
    for (int c = 0; c < 10; c++) begin
      cycle();
      check($sformatf("bp_tready_c%0d", c), 32'(tready), 32'd0);
      check($sformatf("bp_valid_c%0d", c),  32'(out_valid), 32'd1);
      check($sformatf("bp_slot0_c%0d", c),  out_data[31:0], 32'h3F80_0000);
      check($sformatf("bp_slot15_c%0d", c), out_data[32*15 +: 32], 32'h3F80_000F);
    end
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    release_bank("bp");
    cycle();  // the stalled 0x40000000 is accepted here
    tvalid = 1'b0;
    check("bp_next_slot0", out_data[31:0], 32'h4000_0000);

    // Partial flush: 5 beats in total, then finish on its own cycle.
    for (int k = 1; k < 5; k++) send(32'h4100_0000 + 32'(k), 3'b000, 1'b0);
    cycle();
    flush();
    wait_bank("p5");
    check_bank("p5", 5, 3'b000);
    release_bank("p5");

    // finish together with the 3rd beat.
    send(32'h4200_0001, 3'b000, 1'b0);
    send(32'h4200_0002, 3'b000, 1'b0);
    send(32'h4200_0003, 3'b000, 1'b1);
    wait_bank("p3");
    check_bank("p3", 3, 3'b000);
    release_bank("p3");

    // Empty flush is ignored.
    flush();
    repeat (3) cycle();
    check("empty_valid",  32'(out_valid), 32'd0);
    check("empty_state",  32'(dbg_state), 32'd1);
    check("empty_tready", 32'(tready),    32'd1);

    // Flags: underflow on beat 2, invalid op on beat 9.
    for (int k = 0; k < 10; k++)
      send(32'h4300_0000 + 32'(k), (k == 2) ? 3'b001 : (k == 9) ? 3'b100 : 3'b000, 1'b0);
    flush();
    wait_bank("flg");
    check_bank("flg", 10, 3'b101);
    release_bank("flg");
    send(32'h4400_0000, 3'b000, 1'b0);
    send(32'h4400_0001, 3'b000, 1'b1);
    wait_bank("flg0");
    check_bank("flg0", 2, 3'b000);

    // Reset while a bank is held.
    #2;
    sys_rst = 1'b1;
    #1;
    check("mrst_valid",  32'(out_valid), 32'd0);
    check("mrst_tready", 32'(tready),    32'd0);
    check("mrst_count",  32'(out_count), 32'd0);
    check("mrst_flags",  32'(out_flags), 32'd0);
    check("mrst_slot0",  out_data[31:0], 32'h0);
    check("mrst_state",  32'(dbg_state), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    #1;
    check("mrst_init_tready", 32'(tready), 32'd0);
    cycle();
    check("mrst_fill_tready", 32'(tready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time limit so that the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
